lights_selector_multi: RTL and testbench
========================================

Name: lights_selector_multi

Overview:
- Parametrised successor to the single-channel lights selector. Drives CHANNELS independent RGB light outputs.
- Each channel has its own button-stepped colour index and a registered palette lookup.
- A shared 2-bit mode selects white, colour, blinking colour or off.
- Sits between the push-button inputs and the LED driver bus. COLOUR_W scales the palette to any per-component depth.

Parameters:
- CHANNELS, 2: number of independent light channels (>=1).
- COLOUR_W, 8: bits per R/G/B component; full intensity is all-ones of COLOUR_W.
- BLINK_DIV, 4: cycles per blink half-period (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- button  in  CHANNELS  per-channel step request, level input, rising edge acts.
- mode  in  2  0=white, 1=colour, 2=blink, 3=off.
- light  out  CHANNELS*3*COLOUR_W  packed outputs. Channel c occupies [c*3*COLOUR_W +: 3*COLOUR_W], ordered R (high), G, B (low).

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
- Values while rst is sampled high, for every channel:
  - index=1, rgb_q=palette(1).
  - button_q=all ones, so a button held through reset gives no edge.
  - blink_cnt=0, blink_on=1.
  - light=all ones regardless of mode.
- Palette (3-bit index; bit2=R, bit1=G, bit0=B; each set bit gives a full component):
  - 1=B, 2=G, 3=G+B, 4=R, 5=R+B, 6=R+G.
  - 0 maps to black, 7 to white; neither is reachable from the counter.
- Edge detect: edge[c] = button[c] & ~button_q[c]. button_q is registered every cycle.
- Index counter, per channel:
  - On edge: 1→2→…→6→1.
  - Illegal value 0 or 7 → 1 on the next edge.
  - Holding a button advances exactly once.
  - Channels are fully independent; simultaneous edges each advance their own channel.
- Palette lookup: registered, 1 cycle (rgb_q[c] <= palette(index[c])).
- Output register, updated every cycle:
  - mode 0: all ones.
  - mode 1: rgb_q.
  - mode 2: blink_on ? rgb_q : 0.
  - mode 3: 0.
- Latency:
  - Button edge sampled at edge n → index at n, rgb_q at n+1, light at n+2.
  - Mode change sampled at edge n → light at n.
- Blink timer, shared:
  - blink_cnt counts 0..BLINK_DIV-1; at terminal count it wraps to 0 and toggles blink_on.
  - Runs in all modes, so blink phase is free-running.
- Mode changes never alter indices.
- Reset mid-operation (mid-blink or mid-press) restores all reset values on the next edge.

Decomposition:
- Package lights_pkg holds:
  - mode localparams MODE_WHITE=0, MODE_COLOUR=1, MODE_BLINK=2, MODE_OFF=3.
  - IDX_MIN=1, IDX_MAX=6, IDX_RESET=1.
  - Palette bit positions for R/G/B.
- One sub-module, colour_palette: COLOUR_W-parametrised registered 3-bit-index→RGB lookup with synchronous reset to palette(1). Instantiated per channel in a generate loop.
- Counter, edge detect, blink timer and output mux live in the top.

Test Plan (CHANNELS=2, COLOUR_W=8, BLINK_DIV=4):
- Reset and release:
  - Hold rst=1 for 3 cycles with mode=1 → light=48'hFFFFFF_FFFFFF.
  - Release rst → two edges later light=48'h0000FF_0000FF.
- Single press and hold:
  - 1-cycle pulse on button[0] → ch0=00FF00 exactly two edges after the sampling edge; ch1 stays 0000FF.
  - Holding button[0] for 5 cycles advances once only (00FFFF).
- Wrap-around:
  - 5 presses on button[1] → ch1=FFFF00.
  - A 6th press → ch1=0000FF.
  - Simultaneous press on both channels advances both.
- Blink:
  - mode=2 → each channel alternates its colour for 4 cycles and 000000 for 4 cycles, repeatedly.
  - mode=1 restores steady colour on the next edge.
- Mode switching:
  - mode=0 → all FF one edge later; mode=3 → all 00.
  - Back to mode=1 → colours as before the switch (indices retained).
- Reset corner cases:
  - button[0] held high across rst deassertion → no advance after reset.
  - rst asserted mid-blink → next edge light=all ones, blink_on=1, indices=1.

Source files
------------

// File: rtl/lights_pkg.sv
// Shared constants for the multi-channel lights selector.
//   - Mode encodings for the 2-bit mode input.
//   - Colour index range and reset value.
//   - Palette bit positions within the 3-bit colour index.
//   - next_index(): step function for the per-channel index counter.
package lights_pkg;

    localparam logic [1:0] MODE_WHITE  = 2'd0;
    localparam logic [1:0] MODE_COLOUR = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    localparam logic [2:0] IDX_MIN   = 3'd1;
    localparam logic [2:0] IDX_MAX   = 3'd6;
    localparam logic [2:0] IDX_RESET = 3'd1;

    localparam int unsigned PAL_R_BIT = 2;
    localparam int unsigned PAL_G_BIT = 1;
    localparam int unsigned PAL_B_BIT = 0;

    // 1..5 step up; 6 wraps to 1. The unreachable values 0 and 7 also
    // recover to 1 on the next step.
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        if (idx >= IDX_MAX || idx < IDX_MIN)
            return IDX_MIN;
        else
            return idx + 3'd1;
    endfunction

endpackage

// File: rtl/lights_selector_multi_palette.sv
// colour_palette: registered 3-bit index -> packed RGB lookup.
//   clk   : system clock
//   rst   : synchronous active-high reset, output returns to palette(IDX_RESET)
//   index : colour index (bit2=R, bit1=G, bit0=B)
//   rgb   : {R, G, B}, each COLOUR_W bits, all-ones when the bit is set
import lights_pkg::*;

module colour_palette #(
    parameter int COLOUR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              index,
    output logic [3*COLOUR_W-1:0]   rgb
);

    localparam logic [3*COLOUR_W-1:0] RGB_RESET = {
        {COLOUR_W{IDX_RESET[PAL_R_BIT]}},
        {COLOUR_W{IDX_RESET[PAL_G_BIT]}},
        {COLOUR_W{IDX_RESET[PAL_B_BIT]}}
    };

    logic [3*COLOUR_W-1:0] rgb_d;
    logic [3*COLOUR_W-1:0] rgb_q;

    always_comb begin
        rgb_d = {
            {COLOUR_W{index[PAL_R_BIT]}},
            {COLOUR_W{index[PAL_G_BIT]}},
            {COLOUR_W{index[PAL_B_BIT]}}
        };
    end

    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= RGB_RESET;
        else
            rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/lights_selector_multi.sv
// lights_selector_multi: CHANNELS independent button-stepped RGB lights.
//   clk    : system clock, all state on rising edge
//   rst    : synchronous active-high reset
//   button : per-channel step request, rising edge advances that channel
//   mode   : 0=white, 1=colour, 2=blink, 3=off (shared by all channels)
//   light  : channel c at [c*3*COLOUR_W +: 3*COLOUR_W], R high, B low
import lights_pkg::*;

module lights_selector_multi #(
    parameter int CHANNELS  = 2,
    parameter int COLOUR_W  = 8,
    parameter int BLINK_DIV = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              button,
    input  logic [1:0]                       mode,
    output logic [CHANNELS*3*COLOUR_W-1:0]   light
);

    localparam int CH_W  = 3 * COLOUR_W;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CHANNELS-1:0]            button_d, button_q;
    logic [CHANNELS-1:0]            btn_edge;
    logic [CHANNELS-1:0][2:0]       index_d, index_q;
    logic [CHANNELS-1:0][CH_W-1:0]  rgb;
    logic [CNT_W-1:0]               blink_cnt_d, blink_cnt_q;
    logic                           blink_on_d, blink_on_q;
    logic [CHANNELS*CH_W-1:0]       light_d, light_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_palette
        colour_palette #(.COLOUR_W(COLOUR_W)) u_palette (
            .clk   (clk),
            .rst   (rst),
            .index (index_q[g]),
            .rgb   (rgb[g])
        );
    end

    always_comb begin
        button_d = button;
        btn_edge = button & ~button_q;

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            index_d[c] = index_q[c];
            if (btn_edge[c])
                index_d[c] = next_index(index_q[c]);
        end

        // Free-running in every mode so the blink phase never depends on mode history.
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end

        light_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_WHITE:  light_d[c*CH_W +: CH_W] = '1;
                MODE_COLOUR: light_d[c*CH_W +: CH_W] = rgb[c];
                MODE_BLINK:  light_d[c*CH_W +: CH_W] = blink_on_q ? rgb[c] : '0;
                default:     light_d[c*CH_W +: CH_W] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // All-ones history: a button held through reset produces no edge.
            button_q    <= '1;
            index_q     <= {CHANNELS{IDX_RESET}};
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            light_q     <= '1;
        end else begin
            button_q    <= button_d;
            index_q     <= index_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            light_q     <= light_d;
        end
    end

    assign light = light_q;

endmodule

// File: tb/tb_lights_selector_multi.sv
// Self-checking bench for lights_selector_multi (CHANNELS=2, COLOUR_W=8, BLINK_DIV=4).
// A behavioural model counts presses per channel and elapsed cycles since
// reset, and derives the expected light word every cycle; directed literal
// checks pin the model at the key points of the sequence.
module tb_lights_selector_multi;

    localparam int CHANNELS  = 2;
    localparam int COLOUR_W  = 8;
    localparam int BLINK_DIV = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  button;
    logic [1:0]  mode;
    logic [47:0] light;

    int n_vec = 0;
    int n_err = 0;

    lights_selector_multi #(
        .CHANNELS  (CHANNELS),
        .COLOUR_W  (COLOUR_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .mode   (mode),
        .light  (light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [23:0] pal(input int idx);
        logic [23:0] v;
        v = 24'h0;
        if ((idx & 4) != 0) v = v | 24'hFF0000;
        if ((idx & 2) != 0) v = v | 24'h00FF00;
        if ((idx & 1) != 0) v = v | 24'h0000FF;
        return v;
    endfunction

    int          presses [2];
    bit   [1:0]  btn_prev;
    int          cyc;
    logic [23:0] rgb_m [2];
    logic [47:0] exp_light;
    bit          valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            presses[0] = 0;
            presses[1] = 0;
            btn_prev   = 2'b11;
            cyc        = 0;
            rgb_m[0]   = pal(1);
            rgb_m[1]   = pal(1);
            exp_light  = '1;
            valid      = 1;
        end else if (valid) begin
            bit on;
            on = ((cyc / BLINK_DIV) % 2) == 0;
            for (int c = 0; c < 2; c++) begin
                case (mode)
                    2'd0: exp_light[c*24 +: 24] = 24'hFFFFFF;
                    2'd1: exp_light[c*24 +: 24] = rgb_m[c];
                    2'd2: exp_light[c*24 +: 24] = on ? rgb_m[c] : 24'h0;
                    default: exp_light[c*24 +: 24] = 24'h0;
                endcase
            end
            // colour visible one cycle after the index it reflects
            for (int c = 0; c < 2; c++) rgb_m[c] = pal(1 + presses[c] % 6);
            for (int c = 0; c < 2; c++)
                if (button[c] && !btn_prev[c]) presses[c]++;
            btn_prev = button;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (valid) check("model", light, exp_light);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] which);
        button = which;
        step(1);
        button = 2'b00;
        step(1);
    endtask

    initial begin
        int zeros;
        rst = 1'b1; button = 2'b00; mode = 2'd1;
        step(3);
        check("reset_all_ones", light, 48'hFFFFFF_FFFFFF);

        rst = 1'b0;
        step(2);
        check("release_idx1", light, 48'h0000FF_0000FF);

        // single pulse on ch0: sampled at edge n, visible at n+2
        button = 2'b01;
        step(1);
        button = 2'b00;
        check("pulse_n", light, 48'h0000FF_0000FF);
        step(1);
        check("pulse_n1", light, 48'h0000FF_0000FF);
        step(1);
        check("pulse_n2", light, 48'h0000FF_00FF00);

        // held for 5 cycles advances once
        button = 2'b01;
        step(5);
        button = 2'b00;
        step(2);
        check("hold_once", light, 48'h0000FF_00FFFF);

        // wrap-around on ch1
        repeat (5) press(2'b10);
        step(2);
        check("ch1_idx6", light, 48'hFFFF00_00FFFF);
        press(2'b10);
        step(2);
        check("ch1_wrap", light, 48'h0000FF_00FFFF);

        // simultaneous edges
        press(2'b11);
        step(2);
        check("both_adv", light, 48'h00FF00_FF0000);

        // blink: over any 16 consecutive cycles exactly 8 are dark
        mode = 2'd2;
        step(1);
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            if (light == 48'h0) zeros++;
            step(1);
        end
        check("blink_dark_cycles", 48'(zeros), 48'd8);
        mode = 2'd1;
        step(1);
        check("blink_exit", light, 48'h00FF00_FF0000);

        // mode switching retains indices
        mode = 2'd0;
        step(1);
        check("mode_white", light, 48'hFFFFFF_FFFFFF);
        mode = 2'd3;
        step(1);
        check("mode_off", light, 48'h000000_000000);
        mode = 2'd1;
        step(1);
        check("mode_back", light, 48'h00FF00_FF0000);

        // button held across reset release gives no edge
        button = 2'b01; rst = 1'b1; mode = 2'd2;
        step(2);
        check("rst_held_btn", light, 48'hFFFFFF_FFFFFF);
        mode = 2'd1; rst = 1'b0;
        step(3);
        check("no_adv_after_rst", light, 48'h0000FF_0000FF);
        button = 2'b00;
        step(2);
        check("still_idx1", light, 48'h0000FF_0000FF);

        // advance, then reset mid-blink
        press(2'b11);
        mode = 2'd2;
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_mid_blink", light, 48'hFFFFFF_FFFFFF);
        rst = 1'b0;
        step(1);
        check("blink_on_after_rst", light, 48'h0000FF_0000FF);
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
